// File: rtl/radix4_deserializer_pkg.sv
// Shared constants and types for the radix-4 digit deserializer.
package radix4_pkg;

  localparam int unsigned DIGIT_W       = 2;
  localparam int unsigned DEFAULT_WIDTH = 1028;

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    HOLD
  } state_e;

endpackage

// File: rtl/radix4_deserializer_if.sv
// Digit-in / word-out handshake bundle for radix4_deserializer.
// slave: the deserializer. master: the producer/consumer side.
interface radix4_deserializer_if #(
  parameter int unsigned WIDTH = radix4_pkg::DEFAULT_WIDTH
);

  logic                            in_valid;
  logic [radix4_pkg::DIGIT_W-1:0]  in_digit;
  logic                            in_ready;
  logic [WIDTH-1:0]                out_number;
  logic                            out_valid;
  logic                            out_ready;

  modport master (
    output in_valid,
    output in_digit,
    output out_ready,
    input  in_ready,
    input  out_number,
    input  out_valid
  );

  modport slave (
    input  in_valid,
    input  in_digit,
    input  out_ready,
    output in_ready,
    output out_number,
    output out_valid
  );

endinterface

// File: rtl/radix4_digit_counter.sv
// Saturating digit counter with synchronous clear. Flags the accept that
// completes the operand so the FSM can move to HOLD on the same edge.
module radix4_digit_counter #(
  parameter int unsigned NDIG  = 514,
  parameter int unsigned CNT_W = $clog2(NDIG + 1)
) (
  input  logic             clk,
  input  logic             restn,
  input  logic             clear,
  input  logic             inc,
  output logic [CNT_W-1:0] count,
  output logic             last
);

  localparam logic [CNT_W-1:0] CountMax  = CNT_W'(NDIG);
  localparam logic [CNT_W-1:0] CountLast = CNT_W'(NDIG - 1);

  logic [CNT_W-1:0] count_q;

  // Count accepted digits; clear wins, and the count parks at NDIG.
  always_ff @(posedge clk or negedge restn) begin
    if (!restn) begin
      count_q <= '0;
    end else if (clear) begin
      count_q <= '0;
    end else if (inc && (count_q != CountMax)) begin
      count_q <= count_q + CNT_W'(1);
    end
  end

  assign count = count_q;
  assign last  = inc && (count_q == CountLast);

endmodule

// File: rtl/radix4_deserializer.sv
// Rebuilds a WIDTH-bit operand from a stream of 2-bit digits.
// Default build shifts digits in LSB-first (first digit lands at [1:0]).
// Define RADIX4_DESER_MSB_FIRST_EN to shift MSB-first instead.
// WIDTH must be even and at least 4.
module radix4_deserializer
  import radix4_pkg::*;
#(
  parameter  int unsigned WIDTH = DEFAULT_WIDTH,
  localparam int unsigned NDIG  = WIDTH / 2,
  localparam int unsigned CNT_W = $clog2(NDIG + 1)
) (
  input  logic                  clk,
  input  logic                  restn,
  input  logic                  start,
  radix4_deserializer_if.slave  bus,
  output logic                  busy,
  output logic [CNT_W-1:0]      digit_count
);

  state_e           state_q;
  logic [WIDTH-1:0] shreg_q;
  logic [WIDTH-1:0] shreg_d;
  logic             in_ready;
  logic             accept;
  logic             clear;
  logic             inc;
  logic             last;

  assign in_ready = (state_q == COLLECT);
  assign accept   = bus.in_valid && in_ready;
  // start re-arms from IDLE/COLLECT, but in HOLD only together with out_ready.
  assign clear    = start && ((state_q != HOLD) || bus.out_ready);
  // A digit arriving alongside start is dropped.
  assign inc      = accept && !start;

  radix4_digit_counter #(
    .NDIG  (NDIG),
    .CNT_W (CNT_W)
  ) u_counter (
    .clk   (clk),
    .restn (restn),
    .clear (clear),
    .inc   (inc),
    .count (digit_count),
    .last  (last)
  );

  // Next shift-register value for an accepted digit.
  always_comb begin
    shreg_d = shreg_q;
`ifdef RADIX4_DESER_MSB_FIRST_EN
    shreg_d = {shreg_q[WIDTH-3:0], bus.in_digit};
`else
    shreg_d = {bus.in_digit, shreg_q[WIDTH-1:2]};
`endif
  end

  // Operand shift register: cleared on (re)start, shifted on each accept.
  always_ff @(posedge clk or negedge restn) begin
    if (!restn) begin
      shreg_q <= '0;
    end else if (clear) begin
      shreg_q <= '0;
    end else if (inc) begin
      shreg_q <= shreg_d;
    end
  end

  // Collection FSM.
  always_ff @(posedge clk or negedge restn) begin
    if (!restn) begin
      state_q <= IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) state_q <= COLLECT;
        end
        COLLECT: begin
          if (start)     state_q <= COLLECT;
          else if (last) state_q <= HOLD;
        end
        HOLD: begin
          if (bus.out_ready) state_q <= start ? COLLECT : IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.in_ready   = in_ready;
  assign bus.out_valid  = (state_q == HOLD);
  assign bus.out_number = shreg_q;
  assign busy           = (state_q != IDLE);

endmodule

// File: tb/tb_radix4_deserializer.sv
// Directed bench for radix4_deserializer: an 8-bit and a 1028-bit instance.
module tb_radix4_deserializer;
  import radix4_pkg::*;

`ifdef RADIX4_DESER_MSB_FIRST_EN
  localparam logic [7:0] EXP1 = 8'h6C;
  localparam logic [7:0] EXP4 = 8'h01;
`else
  localparam logic [7:0] EXP1 = 8'h39;
  localparam logic [7:0] EXP4 = 8'h40;
`endif

  logic clk = 1'b0;
  logic restn = 1'b0;
  always #5 clk = ~clk;

  logic       n_start, w_start;
  logic       n_busy, w_busy;
  logic [2:0] n_cnt;
  logic [9:0] w_cnt;

  radix4_deserializer_if #(.WIDTH(8))    n_if ();
  radix4_deserializer_if #(.WIDTH(1028)) w_if ();

  radix4_deserializer #(.WIDTH(8)) u_narrow (
    .clk         (clk),
    .restn       (restn),
    .start       (n_start),
    .bus         (n_if),
    .busy        (n_busy),
    .digit_count (n_cnt)
  );

  radix4_deserializer #(.WIDTH(1028)) u_wide (
    .clk         (clk),
    .restn       (restn),
    .start       (w_start),
    .bus         (w_if),
    .busy        (w_busy),
    .digit_count (w_cnt)
  );

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0]    n_q[$];
  logic [1027:0] w_q[$];
  logic [7:0]    nm;
  logic [1027:0] wm;

  function automatic logic [7:0] m8(input logic [7:0] s, input logic [1:0] d);
`ifdef RADIX4_DESER_MSB_FIRST_EN
    return {s[5:0], d};
`else
    return {d, s[7:2]};
`endif
  endfunction

  function automatic logic [1027:0] mw(input logic [1027:0] s, input logic [1:0] d);
`ifdef RADIX4_DESER_MSB_FIRST_EN
    return {s[1025:0], d};
`else
    return {d, s[1027:2]};
`endif
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one digit for a cycle, assuming it is accepted, and advance the model.
  task automatic n_digit(input logic [1:0] d);
    n_if.in_valid = 1'b1;
    n_if.in_digit = d;
    nm = m8(nm, d);
    step();
    n_if.in_valid = 1'b0;
  endtask

  task automatic n_pop_check(input string tag);
    chk({tag, "_qsize"}, n_q.size(), 1);
    if (n_q.size() != 0) chk(tag, {24'd0, n_if.out_number}, {24'd0, n_q.pop_front()});
  endtask

  initial begin
    int acc;
    int guard;
    logic v;
    logic rdy;
    logic [1027:0] wexp;

    n_start = 1'b0;
    w_start = 1'b0;
    n_if.in_valid = 1'b0; n_if.in_digit = 2'b00; n_if.out_ready = 1'b0;
    w_if.in_valid = 1'b0; w_if.in_digit = 2'b00; w_if.out_ready = 1'b0;
    nm = '0;
    wm = '0;

    // Reset state
    #2;
    chk("rst_in_ready", n_if.in_ready, 0);
    chk("rst_out_valid", n_if.out_valid, 0);
    chk("rst_busy", n_busy, 0);
    chk("rst_number", n_if.out_number, 0);
    chk("rst_count", n_cnt, 0);
    chk("rst_w_busy", w_busy, 0);
    @(posedge clk); #1;
    restn = 1'b1;
    step();

    // Basic LSB/MSB assembly, back-to-back digits
    nm = '0;
    n_start = 1'b1;
    step();
    n_start = 1'b0;
    chk("t1_in_ready", n_if.in_ready, 1);
    chk("t1_count0", n_cnt, 0);
    chk("t1_busy", n_busy, 1);
    n_digit(2'b01);
    n_digit(2'b10);
    n_digit(2'b11);
    chk("t1_ov_early", n_if.out_valid, 0);
    n_digit(2'b00);
    n_q.push_back(nm);
    chk("t1_out_valid", n_if.out_valid, 1);
    chk("t1_in_ready_low", n_if.in_ready, 0);
    chk("t1_count4", n_cnt, 4);
    chk("t1_const", n_if.out_number, EXP1);
    n_pop_check("t1_number");

    // HOLD without out_ready, lone start ignored
    repeat (10) step();
    chk("hold_ov", n_if.out_valid, 1);
    chk("hold_number", n_if.out_number, EXP1);
    n_start = 1'b1;
    step();
    n_start = 1'b0;
    chk("hold_start_ov", n_if.out_valid, 1);
    chk("hold_start_ir", n_if.in_ready, 0);
    chk("hold_start_num", n_if.out_number, EXP1);
    // start together with out_ready restarts with no idle cycle
    n_start = 1'b1;
    n_if.out_ready = 1'b1;
    step();
    n_start = 1'b0;
    n_if.out_ready = 1'b0;
    chk("restart_ir", n_if.in_ready, 1);
    chk("restart_ov", n_if.out_valid, 0);
    chk("restart_count", n_cnt, 0);
    chk("restart_num", n_if.out_number, 0);

    // Abort mid-collect; digit alongside start is dropped
    nm = '0;
    n_digit(2'b10);
    n_digit(2'b01);
    chk("abort_count2", n_cnt, 2);
    n_start = 1'b1;
    n_if.in_valid = 1'b1;
    n_if.in_digit = 2'b11;
    step();
    n_start = 1'b0;
    n_if.in_valid = 1'b0;
    chk("abort_count0", n_cnt, 0);
    chk("abort_num0", n_if.out_number, 0);
    chk("abort_ir", n_if.in_ready, 1);
    nm = '0;
    n_digit(2'b00);
    n_digit(2'b00);
    n_digit(2'b00);
    n_digit(2'b01);
    n_q.push_back(nm);
    chk("abort_ov", n_if.out_valid, 1);
    chk("abort_const", n_if.out_number, EXP4);
    n_pop_check("abort_number");
    // in_valid ignored in HOLD; count saturates
    n_if.in_valid = 1'b1;
    n_if.in_digit = 2'b11;
    step();
    step();
    n_if.in_valid = 1'b0;
    chk("hold_sat_count", n_cnt, 4);
    chk("hold_sat_num", n_if.out_number, EXP4);
    n_if.out_ready = 1'b1;
    step();
    n_if.out_ready = 1'b0;
    chk("drain_ov", n_if.out_valid, 0);
    chk("drain_busy", n_busy, 0);
    chk("drain_ir", n_if.in_ready, 0);

    // Asynchronous reset mid-collect
    n_start = 1'b1;
    step();
    n_start = 1'b0;
    n_digit(2'b01);
    n_digit(2'b10);
    n_digit(2'b11);
    chk("arst_pre_count", n_cnt, 3);
    #2 restn = 1'b0;
    #1;
    chk("arst_num", n_if.out_number, 0);
    chk("arst_count", n_cnt, 0);
    chk("arst_busy", n_busy, 0);
    chk("arst_ir", n_if.in_ready, 0);
    chk("arst_ov", n_if.out_valid, 0);
    step();
    restn = 1'b1;
    n_if.in_valid = 1'b1;
    n_if.in_digit = 2'b11;
    repeat (3) step();
    n_if.in_valid = 1'b0;
    chk("post_rst_count", n_cnt, 0);
    chk("post_rst_ir", n_if.in_ready, 0);
    chk("post_rst_num", n_if.out_number, 0);

    // Full-width operand with random in_valid gaps
    wm = '0;
    w_start = 1'b1;
    step();
    w_start = 1'b0;
    acc = 0;
    guard = 0;
    while (acc < 514 && guard < 5000) begin
      v = 1'($urandom_range(0, 1));
      w_if.in_valid = v;
      w_if.in_digit = 2'b11;
      rdy = w_if.in_ready;
      if (acc == 513 && v) chk("w_ov_before_last", w_if.out_valid, 0);
      step();
      if (v && rdy) begin
        acc++;
        wm = mw(wm, 2'b11);
      end
      guard++;
    end
    w_if.in_valid = 1'b0;
    chk("w_accepts", acc, 514);
    w_q.push_back(wm);
    chk("w_out_valid", w_if.out_valid, 1);
    chk("w_in_ready_low", w_if.in_ready, 0);
    chk("w_count", w_cnt, 514);
    chk("w_all_ones", &w_if.out_number, 1);
    chk("w_qsize", w_q.size(), 1);
    if (w_q.size() != 0) begin
      wexp = w_q.pop_front();
      chk("w_number_model", w_if.out_number === wexp, 1);
    end
    w_if.out_ready = 1'b1;
    step();
    w_if.out_ready = 1'b0;
    chk("w_drain_ov", w_if.out_valid, 0);
    chk("w_drain_busy", w_busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
